// File: rtl/instruction_utils.sv
// Shared instruction-path types: a fetched word paired with its PC.
package instruction_utils;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/grant/response plus decode valid/ready and redirect.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with flush; head is the registered oldest entry.
module fetch_fifo
  import instruction_utils::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

  assert property (@(posedge clk) disable iff (!reset) !(do_push && count_q == DEPTH_W));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled fetch stage with credit-limited in-order imem requests and a decode-side FIFO.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when nothing is buffered.
module fetch_unit
  import instruction_utils::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic          run_q, run_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
  fetch_entry_t  shown_q, shown_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head, resp_entry, instr_out;
  logic [CW:0]   credit_used;
  logic          grant, keep, push, pop, bypass_hit, instr_valid;
  logic [31:0]   redirect_base;
  logic          unused_redirect_lsb;

  assign redirect_base       = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Every granted word must have a FIFO slot waiting for it, so credit counts in-flight plus buffered.
  assign credit_used  = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign bus.imem_req = run_q & ~bus.redirect & (credit_used < DEPTH_W);
  assign bus.imem_addr = fetch_pc_q;

  assign grant      = bus.imem_req & bus.imem_gnt;
  assign keep       = bus.imem_rvalid & (discard_q == '0);
  assign resp_entry = '{pc: resp_pc_q, instr: bus.imem_rdata};

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = keep & ~bus.redirect & fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign instr_valid = ~fifo_empty | bypass_hit;
  assign pop         = ~fifo_empty & bus.instr_ready & ~bus.redirect;
  assign push        = keep & ~bus.redirect & ~(bypass_hit & bus.instr_ready);

  always_comb begin
    instr_out = shown_q;
    if (!fifo_empty)     instr_out = fifo_head;
    else if (bypass_hit) instr_out = resp_entry;
  end

  assign shown_d = instr_out;

  always_comb begin
    run_d         = 1'b1;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (bus.redirect) begin
      // Words still in flight after this cycle belong to the old path and must be dropped.
      fetch_pc_d    = redirect_base;
      resp_pc_d     = redirect_base;
      outstanding_d = outstanding_q - CW'(bus.imem_rvalid);
      discard_d     = outstanding_q - CW'(bus.imem_rvalid);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
      outstanding_d = outstanding_q + CW'(grant) - CW'(bus.imem_rvalid);
      if (bus.imem_rvalid) begin
        if (discard_q != '0) discard_d = discard_q - CW'(1);
        else                 resp_pc_d = resp_pc_q + 32'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      shown_q       <= '0;
    end else begin
      run_q         <= run_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      shown_q       <= shown_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (resp_entry),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.instr_valid = instr_valid;
  assign bus.instr       = instr_out.instr;
  assign bus.instr_pc    = instr_out.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based memory and decode model predicts every visible output.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int release_cyc = 0;
  int first_valid_cyc = -1;
  int obs_grants = 0;

  // Reference state: memory requests in flight, words waiting for decode, and the fetch address.
  pend_t       pending[$];
  logic [31:0] buffered[$];
  logic [31:0] fetch_pc_m;
  logic [31:0] last_pc_m;
  logic [31:0] last_instr_m;
  bit          run_m;

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic resetDut();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    reset = 1'b0;
    #1;
    checkOutput("rst_imem_req", bus.imem_req, 0);
    checkOutput("rst_imem_addr", bus.imem_addr, RESET_PC);
    checkOutput("rst_instr_valid", bus.instr_valid, 0);
    checkOutput("rst_instr", bus.instr, 0);
    checkOutput("rst_instr_pc", bus.instr_pc, 0);
    pending.delete();
    buffered.delete();
    fetch_pc_m   = RESET_PC;
    last_pc_m    = '0;
    last_instr_m = '0;
    run_m        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    release_cyc     = cyc;
    first_valid_cyc = -1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model past the edge.
  task automatic stepCycle(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc,
                           input int rv_pct, input int min_extra, input int max_extra);
    bit    rv, exp_req, exp_valid, grant;
    pend_t p;
    rv = 1'b0;
    if (pending.size() > 0 && pending[0].due <= cyc && $urandom_range(1, 100) <= rv_pct) rv = 1'b1;
    bus.imem_gnt    = gnt;
    bus.instr_ready = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? word_of(pending[0].addr) : $urandom;
    #1;
    exp_req   = run_m && !redir && (pending.size() + buffered.size() < DEPTH);
    exp_valid = buffered.size() > 0;
    checkOutput("imem_req", bus.imem_req, exp_req);
    checkOutput("imem_addr", bus.imem_addr, fetch_pc_m);
    checkOutput("instr_valid", bus.instr_valid, exp_valid);
    if (exp_valid) begin
      checkOutput("instr_pc", bus.instr_pc, buffered[0]);
      checkOutput("instr", bus.instr, word_of(buffered[0]));
      last_pc_m    = buffered[0];
      last_instr_m = word_of(buffered[0]);
    end else begin
      checkOutput("instr_pc_hold", bus.instr_pc, last_pc_m);
      checkOutput("instr_hold", bus.instr, last_instr_m);
    end
    if (bus.imem_req && gnt) obs_grants++;
    if (bus.instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc - release_cyc;

    grant = exp_req && gnt;
    if (redir) begin
      if (rv) p = pending.pop_front();
      foreach (pending[i]) pending[i].stale = 1'b1;
      buffered.delete();
      fetch_pc_m = {rpc[31:2], 2'b00};
    end else begin
      if (exp_valid && rdy) void'(buffered.pop_front());
      if (rv) begin
        p = pending.pop_front();
        if (!p.stale) buffered.push_back(p.addr);
      end
      if (grant) begin
        p.addr  = fetch_pc_m;
        p.stale = 1'b0;
        p.due   = cyc + 1 + $urandom_range(min_extra, max_extra);
        pending.push_back(p);
        fetch_pc_m = fetch_pc_m + 32'd4;
      end
    end
    run_m = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input int cycles, input int gnt_pct, input int rdy_pct, input int redir_pct,
                               input int rv_pct, input int min_extra, input int max_extra);
    for (int i = 0; i < cycles; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
      stepCycle($urandom_range(1, 100) <= gnt_pct, $urandom_range(1, 100) <= rdy_pct,
                $urandom_range(1, 100) <= redir_pct, rpc, rv_pct, min_extra, max_extra);
    end
  endtask

  initial begin
    $display("[TB] start");
    resetDut();

    // Single-cycle memory, decode always ready: first word reaches decode three cycles after release.
    applyStimulus(20, 100, 100, 0, 100, 0, 0);
    checkOutput("first_valid_cycle", first_valid_cyc, 3);

    // Decode stalled from release: credit allows exactly DEPTH grants.
    resetDut();
    obs_grants = 0;
    applyStimulus(10, 100, 0, 0, 100, 0, 0);
    checkOutput("backpressure_grants", obs_grants, DEPTH);
    applyStimulus(10, 100, 100, 0, 100, 0, 0);

    // Fill the FIFO, then reset mid-operation.
    applyStimulus(8, 100, 0, 0, 100, 0, 0);
    checkOutput("full_before_reset", buffered.size(), DEPTH);
    resetDut();
    applyStimulus(6, 100, 100, 0, 100, 0, 0);

    // Three-cycle latency builds in-flight words, then redirect to an unaligned target alongside a response.
    applyStimulus(10, 100, 100, 0, 100, 2, 2);
    stepCycle(1'b1, 1'b1, 1'b1, 32'h0000_0103, 100, 0, 0);
    applyStimulus(12, 100, 100, 0, 100, 0, 1);

    // Grant withheld: request and address must hold.
    for (int i = 0; i < 5; i++) stepCycle(1'b0, 1'b1, 1'b0, 32'h0, 100, 0, 0);

    // Address wrap past the top of the 32-bit space.
    stepCycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 100, 0, 0);
    applyStimulus(10, 100, 100, 0, 100, 0, 0);

    applyStimulus(1500, 60, 60, 4, 70, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Decoupled instruction fetch stage sitting between the instruction memory port and `decode`. Keeps a fetch PC, issues in-order requests to a variable-latency instruction memory with a request/grant handshake, buffers returned words with their PCs in a small FIFO, and presents them to decode over a valid/ready interface. A redirect from branch resolution flushes buffered words, discards in-flight responses and restarts fetch at the target.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries and maximum in-flight plus buffered words; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `imem_req`  output  1  fetch request.
- `imem_addr`  output  32  word-aligned fetch address.
- `imem_gnt`  input  1  request accepted when `imem_req & imem_gnt`.
- `imem_rvalid`  input  1  response valid; responses arrive in request order, ≥ 1 cycle after grant.
- `imem_rdata`  input  32  instruction word.
- `instr_valid`  output  1  instruction available to decode.
- `instr`  output  32  instruction word.
- `instr_pc`  output  32  PC of `instr`.
- `instr_ready`  input  1  decode accepts; pop on `instr_valid & instr_ready`.
- `redirect`  input  1  flush and restart fetch.
- `redirect_pc`  input  32  restart address; bits [1:0] ignored and treated as 0.

## Operation
- State: `fetch_pc`, `resp_pc` (PC of the next kept response), `outstanding` (granted, not yet returned; $clog2(DEPTH)+1 bits), `discard` (same width), FIFO `count`, `run` flag.
- Reset: `run`=0, `fetch_pc`=`resp_pc`=`RESET_PC`, counters 0, FIFO empty. Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0.
- `run` sets on the first clock edge after `reset` deasserts. It never clears except on reset.
- `imem_req = run & ~redirect & (outstanding + count < DEPTH)`. `imem_addr = fetch_pc`.
- While `imem_req` is high and not granted, `imem_addr` is held stable.
- Grant: `fetch_pc += 4` (mod 2^32). `outstanding += 1`.
- Response: `outstanding -= 1`. If `discard > 0`, the word is dropped and `discard -= 1`. Otherwise push {`resp_pc`, `imem_rdata`} and `resp_pc += 4`.
- Grant and response in the same cycle: `outstanding` is unchanged.
- Redirect (highest priority):
  - FIFO cleared; any same-cycle pop or push is void.
  - `fetch_pc` and `resp_pc` load {`redirect_pc`[31:2],2'b00}.
  - `discard` = `outstanding` − `imem_rvalid`.
  - No grant is possible in the redirect cycle, because `imem_req` is low.
- Credit rule guarantees the FIFO never overflows. A push while full is a design error and is asserted against.
- Empty FIFO: `instr_valid`=0. `instr` and `instr_pc` hold their last values.

## Timing
- Redirect in cycle N: `imem_req` high in N+1 with `imem_addr`=target, provided credit is available.
- Grant in cycle G, response in R ≥ G+1: `instr_valid` in R+1 (registered FIFO output).
- Sustained throughput: one instruction per cycle with single-cycle-latency memory and `instr_ready` held high.
- Decode backpressure: `instr_valid`, `instr` and `instr_pc` stay stable until popped.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight responses arriving after reset release are not supported; the memory is reset together with this block.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the FIFO is empty, `discard`=0, no redirect, and a response arrives, the word drives `instr_valid`/`instr`/`instr_pc` combinationally in cycle R.
  - If `instr_ready` is also high, the word is consumed without entering the FIFO. Otherwise it is pushed.
  - Fetch-to-decode latency drops to R.
- Undefined: always R+1 as above. No combinational path exists from `imem_*` to `instr_*`.

## Structure
- Add to shared package `instruction_utils`: `fetch_entry_t` packed struct {`pc`[31:0], `instr`[31:0]} and constant `INSTR_BYTES`=4.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, `DEPTH` entries, with push, pop, flush, count, and wrap-around read/write pointers. The same clock and reset apply.

## Test plan
- Reset release with 1-cycle memory always granting and `instr_ready`=1 → requests 0x0, 0x4, 0x8… one per cycle; decode sees PC 0x0 in cycle 3 after release (2 without bypass? no: 3 with `FETCH_BYPASS_EN` undefined, 2 with it).
- `instr_ready`=0 for 10 cycles, DEPTH=4 → exactly 4 grants, then `imem_req`=0. On release, PCs 0x0–0xC are delivered in order with no loss.
- Redirect to 0x100 with 3 responses in flight → those 3 words are dropped. Next `instr_pc`=0x100 and no stale PC reaches decode.
- Redirect with `redirect_pc`=0x103 in the same cycle as an `imem_rvalid` and a pop → the response is dropped. Fetch resumes at 0x100 and `discard` accounts for the remaining in-flight words.
- Grant withheld for 5 cycles → `imem_req`/`imem_addr` stay stable throughout. Fetch at 0xFFFF_FFFC wraps to 0x0000_0000.
- Reset asserted while FIFO is full → `instr_valid`=0 and `imem_req`=0 immediately. After release, fetch restarts at `RESET_PC`.
